// File: rtl/mdio_pkg.sv
// Shared constants, FSM state encodings and the frame builder for the MDIO master.
// Pure declarations: no latency, no flow control.
package mdio_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam int         MDIO_FRAME_BITS = 32;

  // Reads fill TA/DATA with ones; those bits are never driven (oe=0) anyway.
  function automatic logic [MDIO_FRAME_BITS-1:0] build_frame(
    input logic        rd,
    input logic [4:0]  phy,
    input logic [4:0]  regad,
    input logic [15:0] wdata
  );
    return {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), phy, regad,
            (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wdata)};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV cycles low then CLK_DIV high; strobes mark the last high cycle.
// Starts low on the first enabled cycle; held low/cleared while disabled; no backpressure.
module mdio_clk_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic msoc_clk,
  input  logic rst,
  input  logic en,
  output logic mdc_o,
  output logic fall_stb,
  output logic rise_end_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge msoc_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  // The sample point and the bit boundary are the same cycle: MDC falls on the next edge.
  assign rise_end_stb = en & wrap & mdc_q;
  assign fall_stb     = rise_end_stb;
  assign mdc_o        = mdc_q;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one command in, full frame out, done_o at 1+(PREAMBLE_BITS+32)*2*CLK_DIV.
// start_i is only honoured in IDLE; busy_o is the sole backpressure.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV       = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        msoc_clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rd_i,
  input  logic [4:0]  phy_addr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [15:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        rd_err_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  logic [2:0]  state_q, state_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [31:0] sh_q, sh_d;
  logic [15:0] shin_q, shin_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  sync_q, sync_d;
  logic        rd_q, rd_d;
  logic        ta_err_q, ta_err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_err_q, rd_err_d;
  logic        mdio_q, mdio_d;
  logic        oe_q, oe_d;
  logic [31:0] frame;
  logic        clk_en, fall_stb, rise_end_stb, smp;

  assign clk_en = (state_q != S_IDLE) && (state_q != S_END);
  assign smp    = sync_q[1];

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .msoc_clk     (msoc_clk),
    .rst          (rst),
    .en           (clk_en),
    .mdc_o        (mdc_o),
    .fall_stb     (fall_stb),
    .rise_end_stb (rise_end_stb)
  );

  always_comb begin
    frame    = build_frame(rd_i, phy_addr_i, reg_addr_i, wdata_i);
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    shin_d   = shin_q;
    rdata_d  = rdata_q;
    sync_d   = {sync_q[0], mdio_i};
    rd_d     = rd_q;
    ta_err_d = ta_err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_err_d = rd_err_q;
    mdio_d   = mdio_q;
    oe_d     = oe_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rd_d   = rd_i;
          busy_d = 1'b1;
          oe_d   = 1'b1;
          if (PREAMBLE_BITS == 0) begin
            state_d  = S_CMD;
            bitcnt_d = 6'd13;
            mdio_d   = frame[31];
            sh_d     = {frame[30:0], 1'b1};
          end else begin
            state_d  = S_PRE;
            bitcnt_d = 6'(PREAMBLE_BITS - 1);
            mdio_d   = 1'b1;
            sh_d     = frame;
          end
        end
      end
      S_PRE: begin
        if (fall_stb) begin
          if (bitcnt_q == 6'd0) begin
            state_d  = S_CMD;
            bitcnt_d = 6'd13;
            mdio_d   = sh_q[31];
            sh_d     = {sh_q[30:0], 1'b1};
          end else begin
            bitcnt_d = bitcnt_q - 6'd1;
          end
        end
      end
      S_CMD: begin
        if (fall_stb) begin
          mdio_d = sh_q[31];
          sh_d   = {sh_q[30:0], 1'b1};
          if (bitcnt_q == 6'd0) begin
            state_d  = S_TA;
            bitcnt_d = 6'd1;
            oe_d     = ~rd_q;
          end else begin
            bitcnt_d = bitcnt_q - 6'd1;
          end
        end
      end
      S_TA: begin
        if (rise_end_stb && rd_q && bitcnt_q == 6'd0)
          ta_err_d = smp;
        if (fall_stb) begin
          mdio_d = sh_q[31];
          sh_d   = {sh_q[30:0], 1'b1};
          if (bitcnt_q == 6'd0) begin
            state_d  = S_DATA;
            bitcnt_d = 6'd15;
          end else begin
            bitcnt_d = bitcnt_q - 6'd1;
          end
        end
      end
      S_DATA: begin
        if (rise_end_stb && rd_q)
          shin_d = {shin_q[14:0], smp};
        if (fall_stb) begin
          if (bitcnt_q == 6'd0) begin
            state_d = S_END;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            mdio_d  = 1'b1;
            if (rd_q) begin
              rdata_d  = {shin_q[14:0], smp};
              rd_err_d = ta_err_q;
            end
          end else begin
            bitcnt_d = bitcnt_q - 6'd1;
            mdio_d   = sh_q[31];
            sh_d     = {sh_q[30:0], 1'b1};
          end
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge msoc_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      sh_q     <= '1;
      shin_q   <= '0;
      rdata_q  <= '0;
      sync_q   <= 2'b11;
      rd_q     <= 1'b0;
      ta_err_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_err_q <= 1'b0;
      mdio_q   <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      shin_q   <= shin_d;
      rdata_q  <= rdata_d;
      sync_q   <= sync_d;
      rd_q     <= rd_d;
      ta_err_q <= ta_err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_err_q <= rd_err_d;
      mdio_q   <= mdio_d;
      oe_q     <= oe_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign rd_err_o  = rd_err_q;
  assign mdio_o    = mdio_q;
  assign mdio_oe_o = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: DUT A (CLK_DIV=2, 32-bit preamble) and DUT B (CLK_DIV=5, no preamble).
// A PHY model drives mdio_i; expected results go through a scoreboard queue.
module tb_mdio_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, rd_in, mdio_in;
  logic [4:0]  phy_in, reg_in;
  logic [15:0] wd_in;

  logic        a_busy, a_done, a_rderr, a_mdc, a_mdio, a_oe;
  logic [15:0] a_rdata;
  logic        b_busy, b_done, b_rderr, b_mdc, b_mdio, b_oe;
  logic [15:0] b_rdata;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32)) dut_a (
    .msoc_clk(clk), .rst(rst), .start_i(start_a), .rd_i(rd_in),
    .phy_addr_i(phy_in), .reg_addr_i(reg_in), .wdata_i(wd_in),
    .busy_o(a_busy), .done_o(a_done), .rdata_o(a_rdata), .rd_err_o(a_rderr),
    .mdc_o(a_mdc), .mdio_o(a_mdio), .mdio_oe_o(a_oe), .mdio_i(mdio_in)
  );

  mdio_master #(.CLK_DIV(5), .PREAMBLE_BITS(0)) dut_b (
    .msoc_clk(clk), .rst(rst), .start_i(start_b), .rd_i(rd_in),
    .phy_addr_i(phy_in), .reg_addr_i(reg_in), .wdata_i(wd_in),
    .busy_o(b_busy), .done_o(b_done), .rdata_o(b_rdata), .rd_err_o(b_rderr),
    .mdc_o(b_mdc), .mdio_o(b_mdio), .mdio_oe_o(b_oe), .mdio_i(mdio_in)
  );

  bit          sel_b;
  logic        mon_mdc, mon_mdio, mon_oe, mon_busy, mon_done, mon_rderr;
  logic [15:0] mon_rdata;
  always_comb begin
    mon_mdc   = sel_b ? b_mdc   : a_mdc;
    mon_mdio  = sel_b ? b_mdio  : a_mdio;
    mon_oe    = sel_b ? b_oe    : a_oe;
    mon_busy  = sel_b ? b_busy  : a_busy;
    mon_done  = sel_b ? b_done  : a_done;
    mon_rderr = sel_b ? b_rderr : a_rderr;
    mon_rdata = sel_b ? b_rdata : a_rdata;
  end

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    logic [15:0] rdata;
    logic        rd_err;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] frame_of(input logic rd, input logic [4:0] phy,
                                           input logic [4:0] rg, input logic [15:0] wd);
    return {2'b01, (rd ? 2'b10 : 2'b01), phy, rg, 2'b10, wd};
  endfunction

  // Builds the expected line activity; read frames only cover the bits the master drives.
  function automatic exp_t make_exp(input int pre, input int div, input logic rd,
                                    input logic [4:0] phy, input logic [4:0] rg,
                                    input logic [15:0] wd, input logic [15:0] rdata,
                                    input logic rd_err);
    exp_t e;
    logic [63:0] one;
    one = 64'h1;
    e.bits = {32'h0, frame_of(rd, phy, rg, wd)} | (((one << pre) - 64'h1) << 32);
    if (rd) e.oe = ((one << (pre + 14)) - 64'h1) << 18;
    else    e.oe = (one << (pre + 32)) - 64'h1;
    e.rdata    = rdata;
    e.rd_err   = rd_err;
    e.done_cyc = 1 + (pre + 32) * 2 * div;
    return e;
  endfunction

  // Issues one command and records MDIO/OE at each MDC rise until done_o or timeout.
  task automatic run_frame(input bit use_b, input int div, input int pre, input logic rd,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                           input bit phy_on, input logic [15:0] pdat, input int glitch,
                           output logic [63:0] bits, output logic [63:0] oes,
                           output int done_cyc, output logic busy1, output logic busy_at_done);
    int limit, j;
    logic prev;
    sel_b = use_b;
    bits = '0; oes = '0; done_cyc = -1; busy_at_done = 1'b1;
    limit = (pre + 32) * 2 * div + 20;
    @(negedge clk);
    rd_in = rd; phy_in = phy; reg_in = rg; wd_in = wd; mdio_in = 1'b1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    busy1 = mon_busy;
    prev = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) @(negedge clk);
      if (k == glitch) begin
        rd_in = ~rd; phy_in = ~phy; reg_in = ~rg; wd_in = ~wd;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end else if (k == glitch + 1) begin
        rd_in = rd; phy_in = phy; reg_in = rg; wd_in = wd;
        start_a = 1'b0; start_b = 1'b0;
      end
      if (mon_done) begin
        done_cyc = k;
        busy_at_done = mon_busy;
        break;
      end
      if (mon_mdc && !prev) begin
        bits = {bits[62:0], mon_mdio};
        oes  = {oes[62:0], mon_oe};
      end
      prev = mon_mdc;
      if (phy_on && ((k - 1) % (2 * div)) == 0) begin
        j = (k - 1) / (2 * div);
        if (j == pre + 15)                       mdio_in = 1'b0;
        else if (j >= pre + 16 && j < pre + 32)  mdio_in = pdat[15 - (j - pre - 16)];
        else                                     mdio_in = 1'b1;
      end
    end
    start_a = 1'b0; start_b = 1'b0; mdio_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; rd_in = 1'b0;
    phy_in = '0; reg_in = '0; wd_in = '0; mdio_in = 1'b1; sel_b = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_mdc, a_mdio, a_oe, a_busy, a_done, a_rderr, a_rdata} !== {6'b010000, 16'h0}) begin
      n_err++;
      $display("FAIL reset_a: got mdc/mdio/oe/busy/done/err=%b%b%b%b%b%b rdata=%h want 010000 0000",
               a_mdc, a_mdio, a_oe, a_busy, a_done, a_rderr, a_rdata);
    end
    n_cmp++;
    if ({b_mdc, b_mdio, b_oe, b_busy, b_done, b_rderr, b_rdata} !== {6'b010000, 16'h0}) begin
      n_err++;
      $display("FAIL reset_b: got mdc/mdio/oe/busy/done/err=%b%b%b%b%b%b rdata=%h want 010000 0000",
               b_mdc, b_mdio, b_oe, b_busy, b_done, b_rderr, b_rdata);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({a_busy, a_mdc, a_oe, b_busy, b_mdc, b_oe} !== 6'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 000000", {a_busy, a_mdc, a_oe, b_busy, b_mdc, b_oe});
    end
  endtask

  // Runs one command, checks line activity and completion against the scoreboard head.
  task automatic check_cmd(input string name, input bit use_b, input int div, input int pre,
                           input logic rd, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input bit phy_on, input logic [15:0] pdat,
                           input int glitch);
    logic [63:0] bits, oes;
    int dc;
    logic b1, bd;
    exp_t e;
    run_frame(use_b, div, pre, rd, phy, rg, wd, phy_on, pdat, glitch, bits, oes, dc, b1, bd);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_sb: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (b1 !== 1'b1) begin n_err++; $display("FAIL %s_busy1: got %b want 1", name, b1); end
    n_cmp++;
    if (dc !== e.done_cyc) begin n_err++; $display("FAIL %s_done_cycle: got %0d want %0d", name, dc, e.done_cyc); end
    n_cmp++;
    if (bd !== 1'b0) begin n_err++; $display("FAIL %s_busy_at_done: got %b want 0", name, bd); end
    n_cmp++;
    if (oes !== e.oe) begin n_err++; $display("FAIL %s_oe: got %h want %h", name, oes, e.oe); end
    n_cmp++;
    if ((bits & e.oe) !== (e.bits & e.oe)) begin
      n_err++;
      $display("FAIL %s_stream: got %h want %h", name, bits & e.oe, e.bits & e.oe);
    end
    n_cmp++;
    if (mon_rdata !== e.rdata) begin n_err++; $display("FAIL %s_rdata: got %h want %h", name, mon_rdata, e.rdata); end
    n_cmp++;
    if (mon_rderr !== e.rd_err) begin n_err++; $display("FAIL %s_rd_err: got %b want %b", name, mon_rderr, e.rd_err); end
  endtask

  task automatic test_write();
    sb.push_back(make_exp(32, 2, 1'b0, 5'd1, 5'd0, 16'h1234, 16'h0000, 1'b0));
    check_cmd("write", 1'b0, 2, 32, 1'b0, 5'd1, 5'd0, 16'h1234, 1'b0, 16'h0, -5);
  endtask

  task automatic test_read_phy();
    sb.push_back(make_exp(32, 2, 1'b1, 5'd3, 5'd2, 16'h0, 16'hBEEF, 1'b0));
    check_cmd("read_phy", 1'b0, 2, 32, 1'b1, 5'd3, 5'd2, 16'h0, 1'b1, 16'hBEEF, -5);
  endtask

  task automatic test_read_nophy();
    sb.push_back(make_exp(32, 2, 1'b1, 5'd7, 5'd9, 16'h0, 16'hFFFF, 1'b1));
    check_cmd("read_nophy", 1'b0, 2, 32, 1'b1, 5'd7, 5'd9, 16'h0, 1'b0, 16'h0, -5);
  endtask

  task automatic test_start_ignored();
    sb.push_back(make_exp(32, 2, 1'b0, 5'd5, 5'd17, 16'hA5C3, 16'hFFFF, 1'b1));
    check_cmd("start_ignored", 1'b0, 2, 32, 1'b0, 5'd5, 5'd17, 16'hA5C3, 1'b0, 16'h0, 150);
  endtask

  task automatic test_back_to_back();
    int dc;
    exp_t e;
    sb.push_back(make_exp(32, 2, 1'b1, 5'd4, 5'd1, 16'h0, 16'hBEEF, 1'b0));
    check_cmd("b2b_first", 1'b0, 2, 32, 1'b1, 5'd4, 5'd1, 16'h0, 1'b1, 16'hBEEF, -5);
    // Still in the done cycle: this strobe must be ignored, the next cycle accepted.
    sb.push_back(make_exp(32, 2, 1'b1, 5'd6, 5'd6, 16'h0, 16'hFFFF, 1'b1));
    rd_in = 1'b1; phy_in = 5'd6; reg_in = 5'd6; start_a = 1'b1; mdio_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL b2b_ignored_in_done: busy got %b want 0", a_busy); end
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++;
    if (a_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_next: busy got %b want 1", a_busy); end
    dc = -1;
    for (int k = 2; k <= 400; k++) begin
      @(negedge clk);
      if (a_done) begin dc = k; break; end
    end
    e = sb.pop_front();
    n_cmp++;
    if (dc !== e.done_cyc) begin n_err++; $display("FAIL b2b_done_cycle: got %0d want %0d", dc, e.done_cyc); end
    n_cmp++;
    if ({a_rderr, a_rdata} !== {e.rd_err, e.rdata}) begin
      n_err++;
      $display("FAIL b2b_second_read: got err=%b rdata=%h want err=%b rdata=%h", a_rderr, a_rdata, e.rd_err, e.rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    sel_b = 1'b0;
    @(negedge clk);
    rd_in = 1'b0; phy_in = 5'd2; reg_in = 5'd3; wd_in = 16'h5555; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (211) @(negedge clk);
    n_cmp++;
    if ({a_busy, a_mdc, a_oe} !== 3'b111) begin
      n_err++;
      $display("FAIL mid_data_state: busy/mdc/oe got %b want 111", {a_busy, a_mdc, a_oe});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_mdc, a_mdio, a_oe, a_busy, a_done, a_rderr, a_rdata} !== {6'b010000, 16'h0}) begin
      n_err++;
      $display("FAIL reset_mid: got mdc/mdio/oe/busy/done/err=%b%b%b%b%b%b rdata=%h want 010000 0000",
               a_mdc, a_mdio, a_oe, a_busy, a_done, a_rderr, a_rdata);
    end
    seen_done = 1'b0;
    repeat (3) begin @(negedge clk); seen_done |= a_done; end
    rst = 1'b0;
    repeat (300) begin @(negedge clk); seen_done |= a_done | a_busy; end
    n_cmp++;
    if (seen_done !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_done: activity got %b want 0", seen_done); end
    sb.push_back(make_exp(32, 2, 1'b0, 5'd2, 5'd3, 16'h5555, 16'h0000, 1'b0));
    check_cmd("after_reset", 1'b0, 2, 32, 1'b0, 5'd2, 5'd3, 16'h5555, 1'b0, 16'h0, -5);
  endtask

  task automatic test_no_preamble();
    sb.push_back(make_exp(0, 5, 1'b0, 5'h1F, 5'h0A, 16'hC0DE, 16'h0000, 1'b0));
    check_cmd("nopre_write", 1'b1, 5, 0, 1'b0, 5'h1F, 5'h0A, 16'hC0DE, 1'b0, 16'h0, -5);
    sb.push_back(make_exp(0, 5, 1'b1, 5'h11, 5'h04, 16'h0, 16'h3C96, 1'b0));
    check_cmd("nopre_read", 1'b1, 5, 0, 1'b1, 5'h11, 5'h04, 16'h0, 1'b1, 16'h3C96, -5);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_phy();
    test_read_nophy();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_no_preamble();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
